ef_uart_apb: RTL and testbench
==============================

# ef_uart_apb

APB-slave UART peripheral: 8N1 serial transmitter and receiver, each with a 16-entry byte FIFO, a programmable baud prescaler, and a masked, sticky interrupt controller. It sits on the system APB bus as a memory-mapped peripheral, driving the TX pin, sampling the RX pin, and raising one level interrupt toward the CPU.

## Interface

- No parameters. FIFO depth is fixed at 16 entries, data bits at 8, oversampling at 16x.
- PCLK  in  1  Single clock; all logic is rising-edge triggered.
- PRESETn  in  1  Reset: synchronous, active-high (asserted = 1). The APB name is kept; the polarity is as stated here.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  Byte address; only PADDR[15:0] is decoded.
- PWDATA  in  32  Write data.
- PRDATA  out  32  Read data; combinational from PADDR; 0 for unmapped addresses.
- PREADY  out  1  Tied to 1; no wait states.
- RX  in  1  Serial input, idle high. Passed through a 2-flop synchronizer.
- TX  out  1  Serial output, idle high.
- irq  out  1  Level interrupt, equal to |MIS.

## Operation

APB rules:

- A write commits on the clock edge where PSEL & PENABLE & PWRITE are all 1.
- A read side-effect (RXDATA pop) fires on the edge where PSEL & PENABLE & !PWRITE are all 1.

Register map (reset value 0 unless noted):

- 0x0000 RXDATA (R): returns the RX FIFO head in [7:0] and pops it. If the FIFO is empty, returns 0 and nothing is popped.
- 0x0004 TXDATA (W): pushes PWDATA[7:0] into the TX FIFO. The byte is dropped if the FIFO is full.
- 0x0008 PR (RW) [15:0]: prescaler. One baud tick is produced every PR+1 clocks.
- 0x000C CTRL (RW) [2:0]:
  - bit 0 EN: enables the prescaler and both engines.
  - bit 1 TXEN, bit 2 RXEN.
- 0x0010 RXFIFOT (RW) [3:0]: RX FIFO threshold.
- 0x0014 TXFIFOT (RW) [3:0]: TX FIFO threshold.
- 0x0018 LEVELS (R): [4:0] RX FIFO level, [12:8] TX FIFO level.
- 0xFF00 IM (RW) [5:0]: interrupt mask.
- 0xFF04 MIS (R): RIS & IM.
- 0xFF08 RIS (R) [5:0]: raw interrupt status.
- 0xFF0C IC (W): write 1 to a bit to clear that RIS bit. Reads as 0.

RIS bits (0x01, 0x02, …):

- bit 0 TXE: TX FIFO empty.
- bit 1 TXB: TX level < TXFIFOT.
- bit 2 RXF: RX FIFO full.
- bit 3 RXA: RX level > RXFIFOT.
- bit 4 FE: framing error.
- bit 5 OR: RX overrun.

RIS behaviour:

- Every bit is sticky and is set on each cycle its condition holds.
- A set condition takes priority over an IC clear in the same cycle, so a level condition that persists re-asserts immediately.

Prescaler:

- Counter runs 0..PR while EN=1 and emits a tick when it equals PR.
- EN=0 holds the counter at 0.

TX engine (runs when EN & TXEN):

- States: IDLE, START, DATA, STOP.
- IDLE with TX FIFO non-empty: pop one byte, go to START (TX=0).
- DATA: 8 bits, LSB first.
- STOP: TX=1.
- Each state/bit lasts 16 ticks. Return to IDLE after STOP.

RX engine (runs when EN & RXEN):

- IDLE: a synchronized low starts a frame.
- At tick 8 the line is re-checked. If it is high again, treat it as a false start and return to IDLE.
- Then 8 data bits are sampled every 16 ticks (bit centres), LSB first, followed by the stop bit.
- Stop bit = 1: push the byte into the RX FIFO. If the FIFO is full, drop the byte and set OR.
- Stop bit = 0: drop the byte and set FE.

FIFOs:

- 16 entries each, 5-bit level counts.
- Pointers wrap modulo 16.
- A simultaneous push and pop in one cycle leaves the level unchanged.

Disable and reset:

- Clearing EN, TXEN or RXEN returns the affected engine(s) to IDLE immediately, with TX=1.
- FIFO contents and registers are retained.
- Reset clears FIFOs, registers and state machines.

## Timing

Reset values:

- TX=1, irq=0, PRDATA=0 (for address 0).
- PR, CTRL, thresholds, IM and RIS all 0.

Once the engines are enabled, RIS.TXE and RIS.TXB become set one cycle later and stay set while their conditions hold.

Latencies:

- APB writes take effect on the commit edge; register reads reflect the new value on the next cycle.
- TX FIFO write to TX falling (start bit) is at most 2 clocks plus the wait for the next baud tick.
- One frame is 160 ticks = 160·(PR+1) clocks.
- The RX byte is pushed about 8 ticks into the stop bit, plus 2 synchronizer clocks.
- A RIS bit sets one clock after its condition occurs; irq follows RIS/IM combinationally.

## Test plan

- Reset with PRESETn=1 for ≥3 clocks → TX=1, irq=0; reading CTRL, PR, RIS and IM returns 0.
- PR=2, CTRL=7, write TXDATA 0x55 → TX shows start 0, then 1,0,1,0,1,0,1,0, then stop 1; each bit lasts 48 clocks.
- Loopback RX=TX, PR=2, RXFIFOT=7, IM=0x08, CTRL=7, write 0x11..0x88 → irq rises once RX level reaches 8 and MIS=0x08. Eight RXDATA reads return 0x11..0x88 in order; LEVELS[4:0] then reads 0.
- Loopback, send 17 bytes without reading → RIS.RXF set, RIS.OR set, the 17th byte is dropped, and the first 16 are read back intact.
- Drive RX with a frame whose stop bit is 0 → RIS.FE set and the RX level stays 0. A write of 0x10 to IC clears FE.
- RXDATA read while the RX FIFO is empty → returns 0 and the level stays 0. Write 0 to CTRL mid-frame → TX goes high within 1 clock and the TX FIFO level is unchanged.

Source files
------------

// File: rtl/ef_uart_apb.sv
// APB-slave UART: 8N1 TX/RX engines, 16-deep byte FIFOs,
// baud prescaler (16x oversampling) and sticky masked interrupts.
module ef_uart_apb (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   input  logic        RX,
   output logic        TX,
   output logic        irq
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [15:0] a;
   logic        wr, rd, unused;
   logic [15:0] pr, pcnt;
   logic [2:0]  ctrl;
   logic [3:0]  rxfifot, txfifot;
   logic [5:0]  im, ris, icw, cond;
   logic        en, tx_en, rx_en, tick;

   assign a      = PADDR[15:0];
   assign wr     = PSEL & PENABLE & PWRITE;
   assign rd     = PSEL & PENABLE & ~PWRITE;
   assign PREADY = 1'b1;
   assign unused = ^{PADDR[31:16], PWDATA[31:16]};
   assign en     = ctrl[0];
   assign tx_en  = en & ctrl[1];
   assign rx_en  = en & ctrl[2];
   assign tick   = en && (pcnt == pr);

   always_ff @(posedge PCLK) begin
      if (PRESETn) begin
         pr      <= '0;
         ctrl    <= '0;
         rxfifot <= '0;
         txfifot <= '0;
         im      <= '0;
      end else if (wr) begin
         case (a)
            16'h0008: pr      <= PWDATA[15:0];
            16'h000C: ctrl    <= PWDATA[2:0];
            16'h0010: rxfifot <= PWDATA[3:0];
            16'h0014: txfifot <= PWDATA[3:0];
            16'hFF00: im      <= PWDATA[5:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESETn || !en || tick) pcnt <= '0;
      else                        pcnt <= pcnt + 16'd1;
   end

   // TX FIFO
   logic [7:0] txm [16];
   logic [3:0] twp, trp;
   logic [4:0] tlvl;
   logic       tpush, tpop;

   assign tpush = wr && (a == 16'h0004) && (tlvl != 5'd16);

   always_ff @(posedge PCLK) begin
      if (tpush) txm[twp] <= PWDATA[7:0];
   end

   always_ff @(posedge PCLK) begin
      if (PRESETn) begin
         twp  <= '0;
         trp  <= '0;
         tlvl <= '0;
      end else begin
         if (tpush) twp <= twp + 4'd1;
         if (tpop)  trp <= trp + 4'd1;
         tlvl <= tlvl + {4'd0, tpush} - {4'd0, tpop};
      end
   end

   // TX engine
   state_t     ts, ts_n;
   logic [3:0] tc, tc_n;
   logic [2:0] tb, tb_n;
   logic [7:0] tsh, tsh_n;

   always_ff @(posedge PCLK) begin
      if (PRESETn || !tx_en) begin
         ts  <= IDLE;
         tc  <= '0;
         tb  <= '0;
         tsh <= '0;
      end else begin
         ts  <= ts_n;
         tc  <= tc_n;
         tb  <= tb_n;
         tsh <= tsh_n;
      end
   end

   always_comb begin
      ts_n  = ts;
      tc_n  = tc;
      tb_n  = tb;
      tsh_n = tsh;
      tpop  = 1'b0;
      if (tick && tx_en) begin
         tc_n = tc + 4'd1;
         unique case (ts)
            IDLE: begin
               tc_n = '0;
               if (tlvl != 5'd0) begin
                  tpop  = 1'b1;
                  tsh_n = txm[trp];
                  ts_n  = START;
               end
            end
            START: if (tc == 4'd15) ts_n = DATA;
            DATA: if (tc == 4'd15) begin
               tsh_n = tsh >> 1;
               tb_n  = tb + 3'd1;
               if (tb == 3'd7) ts_n = STOP;
            end
            STOP: if (tc == 4'd15) ts_n = IDLE;
            default: ;
         endcase
      end
   end

   assign TX = (ts == START) ? 1'b0 : (ts == DATA) ? tsh[0] : 1'b1;

   // RX synchronizer and engine
   logic       rs1, rs2;
   state_t     rs, rs_n;
   logic [3:0] rc, rc_n;
   logic [2:0] rb, rb_n;
   logic [7:0] rsh, rsh_n;
   logic       rdone, rferr;

   always_ff @(posedge PCLK) begin
      if (PRESETn) begin
         rs1 <= 1'b1;
         rs2 <= 1'b1;
      end else begin
         rs1 <= RX;
         rs2 <= rs1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESETn || !rx_en) begin
         rs  <= IDLE;
         rc  <= '0;
         rb  <= '0;
         rsh <= '0;
      end else begin
         rs  <= rs_n;
         rc  <= rc_n;
         rb  <= rb_n;
         rsh <= rsh_n;
      end
   end

   always_comb begin
      rs_n  = rs;
      rc_n  = rc;
      rb_n  = rb;
      rsh_n = rsh;
      rdone = 1'b0;
      rferr = 1'b0;
      if (tick && rx_en) begin
         rc_n = rc + 4'd1;
         unique case (rs)
            IDLE: begin
               rc_n = '0;
               if (!rs2) rs_n = START;
            end
            // mid start bit: a high line here is a glitch, not a frame
            START: if (rc == 4'd7) begin
               rc_n = '0;
               rs_n = rs2 ? IDLE : DATA;
            end
            DATA: if (rc == 4'd15) begin
               rsh_n = {rs2, rsh[7:1]};
               rb_n  = rb + 3'd1;
               if (rb == 3'd7) rs_n = STOP;
            end
            STOP: if (rc == 4'd15) begin
               rs_n  = IDLE;
               rdone = rs2;
               rferr = ~rs2;
            end
            default: ;
         endcase
      end
   end

   // RX FIFO
   logic [7:0] rxm [16];
   logic [3:0] rwp, rrp;
   logic [4:0] rlvl;
   logic       rpush, rpop, rovr;
   logic [7:0] rx_head;

   assign rpush   = rdone && (rlvl != 5'd16);
   assign rovr    = rdone && (rlvl == 5'd16);
   assign rpop    = rd && (a == 16'h0000) && (rlvl != 5'd0);
   assign rx_head = (rlvl != 5'd0) ? rxm[rrp] : 8'd0;

   always_ff @(posedge PCLK) begin
      if (rpush) rxm[rwp] <= rsh;
   end

   always_ff @(posedge PCLK) begin
      if (PRESETn) begin
         rwp  <= '0;
         rrp  <= '0;
         rlvl <= '0;
      end else begin
         if (rpush) rwp <= rwp + 4'd1;
         if (rpop)  rrp <= rrp + 4'd1;
         rlvl <= rlvl + {4'd0, rpush} - {4'd0, rpop};
      end
   end

   // Interrupts: set wins over clear
   assign icw  = (wr && (a == 16'hFF0C)) ? PWDATA[5:0] : 6'd0;
   assign cond = {rovr, rferr,
                  rlvl > {1'b0, rxfifot}, rlvl == 5'd16,
                  tx_en && (tlvl < {1'b0, txfifot}),
                  tx_en && (tlvl == 5'd0)};
   assign irq  = |(ris & im);

   always_ff @(posedge PCLK) begin
      if (PRESETn) ris <= '0;
      else         ris <= (ris & ~icw) | cond;
   end

   always_comb begin
      PRDATA = '0;
      case (a)
         16'h0000: PRDATA = {24'd0, rx_head};
         16'h0008: PRDATA = {16'd0, pr};
         16'h000C: PRDATA = {29'd0, ctrl};
         16'h0010: PRDATA = {28'd0, rxfifot};
         16'h0014: PRDATA = {28'd0, txfifot};
         16'h0018: PRDATA = {19'd0, tlvl, 3'd0, rlvl};
         16'hFF00: PRDATA = {26'd0, im};
         16'hFF04: PRDATA = {26'd0, ris & im};
         16'hFF08: PRDATA = {26'd0, ris};
         default:  PRDATA = '0;
      endcase
   end
endmodule

// File: tb/tb_ef_uart_apb.sv
// Self-checking bench for ef_uart_apb: APB register access,
// TX waveform, loopback, overrun, framing and disable behaviour.
module tb_ef_uart_apb;
   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b1;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
   logic        PREADY, RX, TX, irq;
   logic        loop = 1'b0, rx_drv = 1'b1;
   int          n_cmp = 0, n_bad = 0;

   assign RX = loop ? TX : rx_drv;
   always #5 PCLK = ~PCLK;

   ef_uart_apb dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .RX(RX), .TX(TX), .irq(irq)
   );

   localparam logic [15:0] A_RXD = 16'h0000, A_TXD = 16'h0004, A_PR = 16'h0008;
   localparam logic [15:0] A_CTRL = 16'h000C, A_RXT = 16'h0010, A_TXT = 16'h0014;
   localparam logic [15:0] A_LVL = 16'h0018, A_IM = 16'hFF00, A_MIS = 16'hFF04;
   localparam logic [15:0] A_RIS = 16'hFF08, A_IC = 16'hFF0C;

   task automatic do_reset();
      loop = 1'b0; rx_drv = 1'b1;
      PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
      @(negedge PCLK); PRESETn = 1'b1;
      repeat (4) @(negedge PCLK);
      PRESETn = 1'b0;
   endtask

   task automatic wr(input logic [15:0] ad, input logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = {16'd0, ad}; PWDATA = d;
      @(negedge PCLK); PENABLE = 1;
      @(negedge PCLK); PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   task automatic rd(input logic [15:0] ad, output logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = {16'd0, ad};
      @(negedge PCLK); PENABLE = 1;
      #1 d = PRDATA;
      @(negedge PCLK); PSEL = 0; PENABLE = 0;
   endtask

   task automatic test_reset();
      logic [15:0] regs [5];
      logic [31:0] d;
      regs = '{A_CTRL, A_PR, A_RIS, A_IM, A_RXD};
      do_reset();
      n_cmp += 3;
      if (TX !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", TX); end
      if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
      if (PREADY !== 1'b1) begin n_bad++; $display("FAIL pready got %b want 1", PREADY); end
      foreach (regs[i]) begin
         rd(regs[i], d);
         n_cmp++;
         if (d !== 32'd0) begin
            n_bad++; $display("FAIL reset_reg_%h got %h want 0", regs[i], d);
         end
      end
   endtask

   task automatic test_tx_frame(input logic [7:0] b, input int p);
      logic [9:0] fr;
      int L, w;
      fr = {1'b1, b, 1'b0};
      L = 16 * (p + 1);
      do_reset();
      wr(A_PR, p); wr(A_CTRL, 7); wr(A_TXD, {24'd0, b});
      w = 0;
      while (TX !== 1'b0 && w < p + 4) begin @(posedge PCLK); #1; w++; end
      n_cmp++;
      if (TX !== 1'b0) begin
         n_bad++; $display("FAIL tx_start_latency got TX=%b after %0d clk want 0", TX, w);
      end else begin
         for (int i = 0; i < 10 * L; i++) begin
            if (i > 0) begin @(posedge PCLK); #1; end
            if (i % L == 0 || i % L == L - 1) begin
               n_cmp++;
               if (TX !== fr[i / L]) begin
                  n_bad++;
                  $display("FAIL tx_bit%0d_clk%0d byte %h got %b want %b",
                           i / L, i % L, b, TX, fr[i / L]);
               end
            end
         end
         @(posedge PCLK); #1;
         n_cmp++;
         if (TX !== 1'b1) begin n_bad++; $display("FAIL tx_idle_after got %b want 1", TX); end
      end
   endtask

   task automatic test_loopback();
      logic [7:0]  q [$];
      logic [31:0] d;
      int p, w;
      do_reset();
      p = $urandom_range(0, 3);
      loop = 1'b1;
      wr(A_PR, p); wr(A_RXT, 7); wr(A_IM, 8'h08); wr(A_CTRL, 7);
      for (int i = 1; i <= 8; i++) begin
         wr(A_TXD, 32'h11 * i);
         q.push_back(8'(8'h11 * i));
      end
      w = 0;
      while (irq !== 1'b1 && w < 8000) begin @(posedge PCLK); #1; w++; end
      n_cmp++;
      if (irq !== 1'b1) begin n_bad++; $display("FAIL loop_irq got %b want 1", irq); end
      rd(A_LVL, d);
      n_cmp++;
      if (d[4:0] !== 5'd8) begin n_bad++; $display("FAIL loop_level_at_irq got %0d want 8", d[4:0]); end
      rd(A_MIS, d);
      n_cmp++;
      if (d !== 32'h08) begin n_bad++; $display("FAIL loop_mis got %h want 08", d); end
      while (q.size() > 0) begin
         logic [7:0] e;
         e = q.pop_front();
         rd(A_RXD, d);
         n_cmp++;
         if (d !== {24'd0, e}) begin n_bad++; $display("FAIL loop_rxdata got %h want %h", d, e); end
      end
      rd(A_LVL, d);
      n_cmp++;
      if (d[4:0] !== 5'd0) begin n_bad++; $display("FAIL loop_level_end got %0d want 0", d[4:0]); end
   endtask

   task automatic test_overrun();
      logic [7:0]  q [$];
      logic [31:0] d;
      int w;
      do_reset();
      loop = 1'b1;
      wr(A_PR, 0); wr(A_CTRL, 7);
      for (int i = 0; i < 17; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         wr(A_TXD, {24'd0, b});
         q.push_back(b);
      end
      w = 0;
      d = '0;
      while (d[5] !== 1'b1 && w < 3000) begin rd(A_RIS, d); w++; end
      n_cmp += 3;
      if (d[5] !== 1'b1) begin n_bad++; $display("FAIL ovr_or got %b want 1", d[5]); end
      if (d[2] !== 1'b1) begin n_bad++; $display("FAIL ovr_rxf got %b want 1", d[2]); end
      rd(A_LVL, d);
      if (d[4:0] !== 5'd16) begin n_bad++; $display("FAIL ovr_level got %0d want 16", d[4:0]); end
      for (int i = 0; i < 16; i++) begin
         rd(A_RXD, d);
         n_cmp++;
         if (d !== {24'd0, q[i]}) begin
            n_bad++; $display("FAIL ovr_rxdata%0d got %h want %h", i, d, q[i]);
         end
      end
      rd(A_RXD, d);
      n_cmp++;
      if (d !== 32'd0) begin n_bad++; $display("FAIL empty_read got %h want 0", d); end
      rd(A_LVL, d);
      n_cmp++;
      if (d[4:0] !== 5'd0) begin n_bad++; $display("FAIL empty_level got %0d want 0", d[4:0]); end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stp, input int L);
      logic [9:0] fr;
      fr = {stp, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         @(negedge PCLK); rx_drv = fr[k];
         repeat (L - 1) @(negedge PCLK);
      end
      @(negedge PCLK); rx_drv = 1'b1;
      repeat (3 * L) @(negedge PCLK);
   endtask

   task automatic test_framing();
      logic [31:0] d;
      logic [7:0]  b;
      int L;
      do_reset();
      L = 32;
      wr(A_PR, 1); wr(A_CTRL, 5);
      b = 8'($urandom);
      send_rx(b, 1'b1, L);
      rd(A_LVL, d);
      n_cmp++;
      if (d[4:0] !== 5'd1) begin n_bad++; $display("FAIL good_frame_level got %0d want 1", d[4:0]); end
      rd(A_RXD, d);
      n_cmp++;
      if (d !== {24'd0, b}) begin n_bad++; $display("FAIL good_frame_data got %h want %h", d, b); end
      @(negedge PCLK); rx_drv = 1'b0;
      repeat (6) @(negedge PCLK);
      rx_drv = 1'b1;
      repeat (3 * L) @(negedge PCLK);
      rd(A_LVL, d);
      n_cmp++;
      if (d[4:0] !== 5'd0) begin n_bad++; $display("FAIL false_start_level got %0d want 0", d[4:0]); end
      rd(A_RIS, d);
      n_cmp++;
      if (d[4] !== 1'b0) begin n_bad++; $display("FAIL false_start_fe got %b want 0", d[4]); end
      send_rx(8'($urandom), 1'b0, L);
      rd(A_RIS, d);
      n_cmp++;
      if (d[4] !== 1'b1) begin n_bad++; $display("FAIL fe_set got %b want 1", d[4]); end
      rd(A_LVL, d);
      n_cmp++;
      if (d[4:0] !== 5'd0) begin n_bad++; $display("FAIL fe_level got %0d want 0", d[4:0]); end
      wr(A_IC, 32'h10);
      rd(A_RIS, d);
      n_cmp++;
      if (d[4] !== 1'b0) begin n_bad++; $display("FAIL fe_clear got %b want 0", d[4]); end
   endtask

   task automatic test_disable();
      logic [31:0] d;
      int w;
      do_reset();
      wr(A_PR, 3); wr(A_TXT, 2); wr(A_CTRL, 7);
      rd(A_RIS, d);
      n_cmp++;
      if (d !== 32'h03) begin n_bad++; $display("FAIL txe_txb_set got %h want 03", d); end
      for (int i = 0; i < 3; i++) wr(A_TXD, $urandom);
      w = 0;
      while (TX !== 1'b0 && w < 20) begin @(posedge PCLK); #1; w++; end
      repeat (30) @(posedge PCLK);
      n_cmp++;
      if (TX !== 1'b0) begin n_bad++; $display("FAIL mid_frame_tx got %b want 0", TX); end
      wr(A_CTRL, 0);
      @(posedge PCLK); #1;
      n_cmp++;
      if (TX !== 1'b1) begin n_bad++; $display("FAIL disable_tx got %b want 1", TX); end
      rd(A_LVL, d);
      n_cmp++;
      if (d[12:8] !== 5'd2) begin n_bad++; $display("FAIL disable_txlevel got %0d want 2", d[12:8]); end
   endtask

   initial begin
      test_reset();
      test_tx_frame(8'h55, 2);
      test_tx_frame(8'($urandom), $urandom_range(0, 3));
      test_loopback();
      test_overrun();
      test_framing();
      test_disable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
